// File: rtl/drive_ctrl_fsm.sv
// Dual H-bridge drive controller.
// One shared PWM period counter produces full, veer and reverse duty strobes.
// A seven-state machine sequences forward/veer driving, collision brake,
// timed reverse back-off, tone-commanded junction handling, timed pivot turns
// and a terminal halt. All H-bridge pins are registered, so they lag the
// state/counter by one clock.
module drive_ctrl_fsm #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int PWM_FREQ_HZ     = 80,
    parameter int FULL_DUTY_PCT   = 80,
    parameter int VEER_DUTY_PCT   = 40,
    parameter int REV_DUTY_PCT    = 60,
    parameter int MAX_DUTY_PCT    = 80,
    parameter int REV_MS          = 500,
    parameter int TURN_MS         = 400,
    parameter int JUNC_TIMEOUT_MS = 3000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [1:0] dir,
    input  logic       colDetect,
    input  logic       junction,
    input  logic [4:0] tone,
    output logic       hbEnA,
    output logic       hbEnB,
    output logic       hbIn1,
    output logic       hbIn2,
    output logic       hbIn3,
    output logic       hbIn4,
    output logic [2:0] state
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int PERIOD = CLK_FREQ_HZ / PWM_FREQ_HZ;
    localparam int MS_CYC = CLK_FREQ_HZ / 1000;

    // Every duty is limited to the bridge ceiling before conversion.
    localparam int FULL_C = (FULL_DUTY_PCT > MAX_DUTY_PCT) ? MAX_DUTY_PCT : FULL_DUTY_PCT;
    localparam int VEER_C = (VEER_DUTY_PCT > MAX_DUTY_PCT) ? MAX_DUTY_PCT : VEER_DUTY_PCT;
    localparam int REV_C  = (REV_DUTY_PCT  > MAX_DUTY_PCT) ? MAX_DUTY_PCT : REV_DUTY_PCT;

    localparam longint ON_FULL_L = (longint'(PERIOD) * FULL_C) / 100;
    localparam longint ON_VEER_L = (longint'(PERIOD) * VEER_C) / 100;
    localparam longint ON_REV_L  = (longint'(PERIOD) * REV_C)  / 100;

    // Counter is wide enough to hold PERIOD itself so a 100% on-count
    // still compares correctly.
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] ON_FULL  = CW'(ON_FULL_L);
    localparam logic [CW-1:0] ON_VEER  = CW'(ON_VEER_L);
    localparam logic [CW-1:0] ON_REV   = CW'(ON_REV_L);

    localparam longint REV_CYC  = longint'(REV_MS)          * MS_CYC;
    localparam longint TURN_CYC = longint'(TURN_MS)         * MS_CYC;
    localparam longint JUNC_CYC = longint'(JUNC_TIMEOUT_MS) * MS_CYC;
    localparam longint MAX_A    = (REV_CYC > TURN_CYC) ? REV_CYC : TURN_CYC;
    localparam longint MAX_CYC  = (MAX_A > JUNC_CYC) ? MAX_A : JUNC_CYC;

    localparam int TW = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

    // A timed state is left on the edge that ends its Nth cycle, i.e. when
    // the per-state timer shows N-1.
    localparam logic [TW-1:0] REV_LAST  = TW'(REV_CYC  - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
    localparam logic [TW-1:0] JUNC_LAST = TW'(JUNC_CYC - 1);

    // ------------------------------------------------------------------
    // State encoding (also driven out on the debug pins)
    // ------------------------------------------------------------------
    localparam logic [2:0] S_FWD    = 3'd0;
    localparam logic [2:0] S_COLL   = 3'd1;
    localparam logic [2:0] S_REV    = 3'd2;
    localparam logic [2:0] S_JUNC   = 3'd3;
    localparam logic [2:0] S_TURN_L = 3'd4;
    localparam logic [2:0] S_TURN_R = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    // H-bridge direction words, ordered {In1, In2, In3, In4}.
    localparam logic [3:0] IN_BRAKE = 4'b0000;
    localparam logic [3:0] IN_FWD   = 4'b0110;  // A fwd, B fwd
    localparam logic [3:0] IN_REV   = 4'b1001;  // A rev, B rev
    localparam logic [3:0] IN_PIV_L = 4'b1010;  // A rev, B fwd
    localparam logic [3:0] IN_PIV_R = 4'b0101;  // A fwd, B rev

    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    state_q, state_d;
    logic          en_a_q, en_a_d;
    logic          en_b_q, en_b_d;
    logic [3:0]    in_q, in_d;

    logic full_pwm, veer_pwm, rev_pwm;
    logic rev_done, turn_done, junc_done;
    logic timed;

    // ------------------------------------------------------------------
    // Shared PWM period counter
    // ------------------------------------------------------------------
    assign cnt_d    = (cnt_q >= CNT_LAST) ? '0 : cnt_q + CW'(1);
    assign full_pwm = (cnt_q < ON_FULL);
    assign veer_pwm = (cnt_q < ON_VEER);
    assign rev_pwm  = (cnt_q < ON_REV);

    // Free-running period counter, restarted by reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // ------------------------------------------------------------------
    // State timer
    // ------------------------------------------------------------------
    // >= rather than == so a corrupted timer still forces an exit.
    assign rev_done  = (timer_q >= REV_LAST);
    assign turn_done = (timer_q >= TURN_LAST);
    assign junc_done = (timer_q >= JUNC_LAST);

    assign timed = (state_q == S_REV) || (state_q == S_JUNC) ||
                   (state_q == S_TURN_L) || (state_q == S_TURN_R);

    // Any state change clears the timer; only timed states let it count.
    assign timer_d = (state_d != state_q) ? '0 :
                     timed                ? timer_q + TW'(1) : '0;

    // Shared per-state timer.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic. Collision always wins over timer expiry and tones.
    // ------------------------------------------------------------------
    // Drive state transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FWD: begin
                if (colDetect)     state_d = S_COLL;
                else if (junction) state_d = S_JUNC;
            end
            S_COLL: begin
                if (!colDetect) state_d = S_REV;
            end
            S_REV: begin
                if (colDetect)     state_d = S_COLL;
                else if (rev_done) state_d = S_FWD;
            end
            S_JUNC: begin
                if (colDetect) begin
                    state_d = S_COLL;
                end else begin
                    // Only a clean single-band tone is a command.
                    case (tone)
                        5'b00001: state_d = S_HALT;
                        5'b00010: state_d = S_FWD;
                        5'b00100: state_d = S_TURN_L;
                        5'b01000: state_d = S_TURN_R;
                        5'b10000: state_d = S_REV;
                        default:  if (junc_done) state_d = S_HALT;
                    endcase
                end
            end
            S_TURN_L, S_TURN_R: begin
                if (colDetect)      state_d = S_COLL;
                else if (turn_done) state_d = S_FWD;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FWD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= S_FWD;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Output decode from current state and PWM strobes
    // ------------------------------------------------------------------
    // H-bridge enable/direction decode; anything unlisted brakes.
    always_comb begin
        en_a_d = 1'b0;
        en_b_d = 1'b0;
        in_d   = IN_BRAKE;
        case (state_q)
            S_FWD: begin
                case (dir)
                    2'b00: begin en_a_d = full_pwm; en_b_d = full_pwm; in_d = IN_FWD; end
                    2'b01: begin en_a_d = veer_pwm; en_b_d = full_pwm; in_d = IN_FWD; end
                    2'b10: begin en_a_d = full_pwm; en_b_d = veer_pwm; in_d = IN_FWD; end
                    default: begin en_a_d = 1'b0; en_b_d = 1'b0; in_d = IN_BRAKE; end
                endcase
            end
            S_REV: begin
                en_a_d = rev_pwm;
                en_b_d = rev_pwm;
                in_d   = IN_REV;
            end
            S_TURN_L: begin
                en_a_d = rev_pwm;
                en_b_d = rev_pwm;
                in_d   = IN_PIV_L;
            end
            S_TURN_R: begin
                en_a_d = rev_pwm;
                en_b_d = rev_pwm;
                in_d   = IN_PIV_R;
            end
            default: begin
                en_a_d = 1'b0;
                en_b_d = 1'b0;
                in_d   = IN_BRAKE;
            end
        endcase
    end

    // Registered H-bridge pins; reset drops them all immediately.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            en_a_q <= 1'b0;
            en_b_q <= 1'b0;
            in_q   <= IN_BRAKE;
        end else begin
            en_a_q <= en_a_d;
            en_b_q <= en_b_d;
            in_q   <= in_d;
        end
    end

    assign hbEnA = en_a_q;
    assign hbEnB = en_b_q;
    assign hbIn1 = in_q[3];
    assign hbIn2 = in_q[2];
    assign hbIn3 = in_q[1];
    assign hbIn4 = in_q[0];
    assign state = state_q;

endmodule

// File: tb/tb_drive_ctrl_fsm.sv
// Bench for drive_ctrl_fsm: directed scenarios followed by randomized
// stimulus. Each driven cycle pushes the reference model's expected pin
// values into a queue; a monitor pops one entry after every clock edge.
module tb_drive_ctrl_fsm;

    localparam int PER      = 100;                    // 100 kHz / 1 kHz
    localparam int MS       = 100;                    // cycles per ms
    localparam int FULL_PCT = (95 < 80) ? 95 : 80;    // requested 95, ceiling 80
    localparam int ON_FULL  = PER * FULL_PCT / 100;
    localparam int ON_VEER  = PER * 40 / 100;
    localparam int ON_REV   = PER * 60 / 100;
    localparam int REV_N    = 2 * MS;
    localparam int TURN_N   = 3 * MS;
    localparam int JUNC_N   = 5 * MS;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       colDetect = 1'b0;
    logic       junction = 1'b0;
    logic [4:0] tone = 5'b0;
    logic       hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4;
    logic [2:0] state;

    drive_ctrl_fsm #(
        .CLK_FREQ_HZ(100_000), .PWM_FREQ_HZ(1000), .FULL_DUTY_PCT(95),
        .VEER_DUTY_PCT(40), .REV_DUTY_PCT(60), .MAX_DUTY_PCT(80),
        .REV_MS(2), .TURN_MS(3), .JUNC_TIMEOUT_MS(5)
    ) dut (
        .clk(clk), .rstN(rstN), .dir(dir), .colDetect(colDetect),
        .junction(junction), .tone(tone),
        .hbEnA(hbEnA), .hbEnB(hbEnB), .hbIn1(hbIn1), .hbIn2(hbIn2),
        .hbIn3(hbIn3), .hbIn4(hbIn4), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ena;
        logic       enb;
        logic [3:0] hin;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: mode, cycles spent in it, cycles since reset.
    int m_state = 0;
    int m_age   = 0;
    int m_cyc   = 0;
    int tone_map[5] = '{6, 0, 4, 5, 2};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic [1:0] d, input logic c, input logic j, input logic [4:0] t);
        obs_t e;
        int   ph, held, nxt;
        e  = '0;
        ph = m_cyc % PER;
        case (m_state)
            0: if (d != 2'b11) begin
                   e.hin = 4'b0110;
                   e.ena = (ph < ((d == 2'b01) ? ON_VEER : ON_FULL));
                   e.enb = (ph < ((d == 2'b10) ? ON_VEER : ON_FULL));
               end
            2: begin e.hin = 4'b1001; e.ena = (ph < ON_REV); e.enb = (ph < ON_REV); end
            4: begin e.hin = 4'b1010; e.ena = (ph < ON_REV); e.enb = (ph < ON_REV); end
            5: begin e.hin = 4'b0101; e.ena = (ph < ON_REV); e.enb = (ph < ON_REV); end
            default: ;
        endcase
        held = m_age + 1;
        nxt  = m_state;
        case (m_state)
            0: nxt = c ? 1 : (j ? 3 : 0);
            1: nxt = c ? 1 : 2;
            2: nxt = c ? 1 : ((held >= REV_N) ? 0 : 2);
            3: begin
                   if (c) nxt = 1;
                   else if ($countones(t) == 1) begin
                       for (int b = 0; b < 5; b++) if (t[b]) nxt = tone_map[b];
                   end else if (held >= JUNC_N) nxt = 6;
               end
            4, 5: nxt = c ? 1 : ((held >= TURN_N) ? 0 : m_state);
            default: nxt = 6;
        endcase
        e.st    = 3'(nxt);
        m_age   = (nxt == m_state) ? m_age + 1 : 0;
        m_state = nxt;
        m_cyc++;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [1:0] d, input logic c, input logic j, input logic [4:0] t);
        @(negedge clk);
        rstN = 1'b1;
        dir = d; colDetect = c; junction = j; tone = t;
        model_step(d, c, j, t);
    endtask

    // Assert reset between edges and confirm the pins drop without a clock.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        check("rst_async_state", 32'(state), 32'd0);
        check("rst_async_pins", 32'({hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4}), 32'd0);
        exp_q.delete();
        m_state = 0; m_age = 0; m_cyc = 0;
    endtask

    // Monitor: compare one expected observation after every edge.
    always @(posedge clk) begin
        obs_t e;
        obs_t a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {state, hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4};
            check("scoreboard", 32'(a), 32'(e));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ca, cb, cs;
        logic c_r;
        logic [1:0] d;
        logic jj;
        logic [4:0] tt;

        repeat (2) @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_pins", 32'({hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4}), 32'd0);

        // Straight: 80/100 both sides (95% request clamped to 80).
        repeat (5) step(2'b00, 0, 0, 0);
        ca = 0; cb = 0;
        repeat (100) begin step(2'b00, 0, 0, 0); ca += int'(hbEnA); cb += int'(hbEnB); end
        check("straight_enA", 32'(ca), 32'd80);
        check("straight_enB", 32'(cb), 32'd80);
        check("straight_in", 32'({hbIn1, hbIn2, hbIn3, hbIn4}), 32'b0110);

        // Veer left: A 40/100, B 80/100.
        repeat (5) step(2'b01, 0, 0, 0);
        ca = 0; cb = 0;
        repeat (100) begin step(2'b01, 0, 0, 0); ca += int'(hbEnA); cb += int'(hbEnB); end
        check("veerL_enA", 32'(ca), 32'd40);
        check("veerL_enB", 32'(cb), 32'd80);
        repeat (50) step(2'b10, 0, 0, 0);
        repeat (50) step(2'b11, 0, 0, 0);

        // Collision then exactly 200 cycles of reverse.
        repeat (50) step(2'b00, 1, 0, 0);
        check("coll_state", 32'(state), 32'd1);
        cs = 0;
        repeat (260) begin step(2'b00, 0, 0, 0); cs += (state == 3'd2) ? 1 : 0; end
        check("rev_len", 32'(cs), 32'(REV_N));

        // Collision pulse in the middle of reverse.
        repeat (10) step(2'b00, 1, 0, 0);
        repeat (100) step(2'b00, 0, 0, 0);
        step(2'b00, 1, 0, 0);
        step(2'b00, 0, 0, 0);
        check("rev_recoll", 32'(state), 32'd1);
        repeat (250) step(2'b00, 0, 0, 0);

        // Junction, tone bp3 -> left pivot for 300 cycles.
        step(2'b00, 0, 1, 5'b00000);
        step(2'b00, 0, 0, 5'b00100);
        cs = 0;
        repeat (400) begin step(2'b00, 0, 0, 0); cs += (state == 3'd4) ? 1 : 0; end
        check("turnL_len", 32'(cs), 32'(TURN_N));
        check("turnL_done", 32'(state), 32'd0);

        // Two bands set is not a command; bp2 then resumes forward.
        step(2'b00, 0, 1, 0);
        repeat (50) step(2'b00, 0, 0, 5'b00011);
        check("junc_multi", 32'(state), 32'd3);
        step(2'b00, 0, 0, 5'b00010);
        step(2'b00, 0, 0, 0);
        check("junc_fwd", 32'(state), 32'd0);

        // Collision on the very cycle the junction timeout expires.
        step(2'b00, 0, 1, 0);
        repeat (JUNC_N - 1) step(2'b00, 0, 0, 0);
        step(2'b00, 1, 0, 0);
        step(2'b00, 0, 0, 0);
        check("expiry_vs_coll", 32'(state), 32'd1);
        repeat (250) step(2'b00, 0, 0, 0);

        // Plain timeout: 500 cycles in JUNC then a sticky halt.
        step(2'b00, 0, 1, 0);
        cs = 0;
        repeat (600) begin step(2'b00, 0, 0, 0); cs += (state == 3'd3) ? 1 : 0; end
        check("junc_timeout_len", 32'(cs), 32'(JUNC_N));
        repeat (100) step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        check("halt_sticky", 32'(state), 32'd6);
        do_reset();

        // Junction pulse during reverse is dropped, not queued.
        repeat (5) step(2'b00, 1, 0, 0);
        repeat (50) step(2'b00, 0, 0, 0);
        step(2'b00, 0, 1, 0);
        cs = 0;
        repeat (300) begin step(2'b00, 0, 0, 0); cs += (state == 3'd3) ? 1 : 0; end
        check("junc_ignored", 32'(cs), 32'd0);

        // Reset in mid-period while driving.
        repeat (37) step(2'b00, 0, 0, 0);
        do_reset();

        // Randomized traffic.
        c_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (m_state == 6 && $urandom_range(0, 19) == 0) begin
                do_reset();
                c_r = 1'b0;
            end
            if (c_r) c_r = ($urandom_range(0, 9) != 0);
            else     c_r = ($urandom_range(0, 499) == 0);
            d  = 2'($urandom_range(0, 3));
            jj = ($urandom_range(0, 99) == 0);
            tt = ($urandom_range(0, 29) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            step(d, c_r, jj, tt);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/drive_ctrl_fsm.md
Name: drive_ctrl_fsm

Overview:
- Parametrised next-generation motor drive controller for the dual H-bridge.
- Generates programmable-duty PWM with a single shared period counter and decodes steering commands from the direction-control block.
- Runs a full drive state machine: forward/veer, collision brake, timed reverse back-off, tone-commanded junction handling, timed pivot turns, terminal halt.
- Sits between the direction-control/tone-detect blocks and the H-bridge pins in the top level.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- PWM_FREQ_HZ, 80, PWM frequency.
- FULL_DUTY_PCT, 80, full-speed duty.
- VEER_DUTY_PCT, 40, veer-side duty.
- REV_DUTY_PCT, 60, reverse and pivot duty.
- MAX_DUTY_PCT, 80, H-bridge ceiling; every duty is clamped to min(duty, MAX_DUTY_PCT).
- REV_MS, 500, reverse back-off duration.
- TURN_MS, 400, pivot-turn duration.
- JUNC_TIMEOUT_MS, 3000, maximum wait for a tone in JUNC.
- Derived: PERIOD = CLK_FREQ_HZ/PWM_FREQ_HZ; ON_x = PERIOD*clamped_x/100 (integer, truncating); MS_CYC = CLK_FREQ_HZ/1000.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- dir  in  2  steering: 00 straight, 01 veer left, 10 veer right, 11 stop.
- colDetect  in  1  collision present, level.
- junction  in  1  junction detected, single-cycle pulse.
- tone  in  5  tone-detector bands bp1..bp5 as bits 0..4, level.
- hbEnA, hbEnB  out  1 each  H-bridge enables (PWM-gated).
- hbIn1, hbIn2, hbIn3, hbIn4  out  1 each  H-bridge direction inputs.
- state  out  3  current state code, for debug/test pin.

Behaviour:
- Reset (rstN=0, asynchronous): state=FWD, PWM counter=0, ms/timer counters=0, all H-bridge outputs 0. Release is synchronous to clk.
- PWM counter: cnt counts 0..PERIOD-1, then wraps to 0.
  - fullPwm = (cnt < ON_FULL); veerPwm = (cnt < ON_VEER); revPwm = (cnt < ON_REV).
  - Duty 0 gives a constant 0 output. Duty clamped to 100 would give constant 1, but the clamp to MAX_DUTY_PCT applies first.
- Outputs: all outputs are registered, one cycle after state/cnt.
- Motor codes:
  - A forward: In1=0, In2=1. A reverse: In1=1, In2=0.
  - B forward: In3=1, In4=0. B reverse: In3=0, In4=1.
  - Brake: both enables 0 and all In 0.
- State codes: FWD=0, COLL=1, REV=2, JUNC=3, TURN_L=4, TURN_R=5, HALT=6.
- FWD: both sides forward.
  - dir=00: EnA=EnB=fullPwm.
  - dir=01: EnA=veerPwm, EnB=fullPwm.
  - dir=10: EnA=fullPwm, EnB=veerPwm.
  - dir=11: brake.
  - Exits, by priority: colDetect gives COLL; else junction gives JUNC.
- COLL: brake. When colDetect is sampled low, go to REV and clear the timer.
- REV: both sides reverse, EnA=EnB=revPwm.
  - After REV_MS*MS_CYC cycles, go to FWD.
  - colDetect re-asserted gives COLL; the timer restarts on the next REV entry.
- JUNC: brake; timer runs. When exactly one tone bit is set (onehot):
  - bit0 gives HALT.
  - bit1 gives FWD.
  - bit2 gives TURN_L.
  - bit3 gives TURN_R.
  - bit4 gives REV.
  - Zero or multiple bits set: stay.
  - Timeout at JUNC_TIMEOUT_MS gives HALT.
  - colDetect overrides tone and goes to COLL.
- TURN_L: A reverse, B forward, both gated by revPwm. After TURN_MS, go to FWD. colDetect gives COLL.
- TURN_R: mirror of TURN_L.
- HALT: brake; exits only on reset; colDetect and tone are ignored.
- Timer rules:
  - One shared timer, cleared on every state entry.
  - Width is ceil(log2(max(REV_MS, TURN_MS, JUNC_TIMEOUT_MS)*MS_CYC+1)).
  - An expiry in the same cycle as colDetect resolves to COLL.
- junction while not in FWD is ignored; it is not queued.
- Unused state codes (7) recover to FWD on the next clock.

Test Plan:
- Params CLK_FREQ_HZ=100_000, PWM_FREQ_HZ=1000 (PERIOD=100, MS_CYC=100), REV_MS=2, TURN_MS=3, JUNC_TIMEOUT_MS=5.
- Straight/veer: dir=00 gives EnA and EnB high 80/100 cycles. dir=01 gives EnA 40/100 and EnB 80/100. In1..4=0,1,1,0 throughout.
- Duty clamp: FULL_DUTY_PCT=95 still gives 80 high cycles per period. Reset mid-period forces outputs 0 immediately (asynchronously) and cnt restarts at 0.
- Collision: colDetect high for 50 cycles gives state=1 and brake. On release, state=2 with In1..4=1,0,0,1 for exactly 200 cycles, then state=0. A colDetect pulse mid-REV returns to state=1.
- Junction tones:
  - junction pulse then tone=00100 gives state=4 for 300 cycles (A reverse, B forward), then state=0.
  - tone=00011 keeps state=3.
  - tone=00001 gives state=6, which persists under colDetect and tone until rstN=0.
- Junction timeout: junction pulse with tone=0 gives state=6 after exactly 500 cycles. colDetect in the same cycle as expiry gives state=1.
- Ignored junction: junction pulse during REV leaves state=2 and does not enter JUNC afterwards.
